banked_unified_memory: RTL and testbench

//   Parametrised successor to the NeoCore unified Von Neumann memory: a single big-endian byte store shared by

---
 rtl/banked_unified_memory_pkg.sv | 32 +++
 rtl/banked_unified_memory_resp_pipe.sv | 57 +++++
 rtl/banked_unified_memory.sv | 134 +++++++++++++
 tb/tb_banked_unified_memory.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_unified_memory_pkg.sv
// Shared types and helpers for the NeoCore unified memory: access-size encoding and
// the set of parameter values the memory supports.
package neocore_mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE    = 2'b00,
    MEM_HALF    = 2'b01,
    MEM_WORD    = 2'b10,
    MEM_ILLEGAL = 2'b11
  } mem_size_e;

  localparam int unsigned FETCH_BYTES_NARROW = 4;
  localparam int unsigned FETCH_BYTES_MID    = 8;
  localparam int unsigned FETCH_BYTES_WIDE   = 16;
  localparam int unsigned READ_LATENCY_MIN   = 1;
  localparam int unsigned READ_LATENCY_MAX   = 2;

  // Byte count of an access; 0 marks the illegal encoding.
  function automatic logic [2:0] size_bytes(input mem_size_e s);
    case (s)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      MEM_WORD: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic bit fetch_bytes_ok(input int unsigned fb);
    return (fb == FETCH_BYTES_NARROW) || (fb == FETCH_BYTES_MID) || (fb == FETCH_BYTES_WIDE);
  endfunction

endpackage

// File: rtl/banked_unified_memory_resp_pipe.sv
// Response delay line (valid/err/data) of 1 or 2 stages with synchronous clear;
// data and err are forced to 0 whenever the stage is not carrying a good response.
module mem_resp_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_err,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_err,
  output logic [WIDTH-1:0] out_data
);

  logic             v1, e1;
  logic [WIDTH-1:0] d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      e1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= in_valid;
      e1 <= in_valid && in_err;
      d1 <= (in_valid && !in_err) ? in_data : '0;
    end
  end

  if (LATENCY == 2) begin : g_out_reg
    logic             v2, e2;
    logic [WIDTH-1:0] d2;

    always_ff @(posedge clk) begin
      if (rst) begin
        v2 <= 1'b0;
        e2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        e2 <= e1;
        d2 <= d1;
      end
    end

    assign out_valid = v2;
    assign out_err   = e2;
    assign out_data  = d2;
  end else begin : g_direct
    assign out_valid = v1;
    assign out_err   = e1;
    assign out_data  = d1;
  end

endmodule

// File: rtl/banked_unified_memory.sv
// Unified big-endian byte store shared by instruction fetch (port A) and load/store (port B),
// with exact bounds checks, error responses and write-first forwarding into same-cycle fetches.
module banked_unified_memory
  import neocore_mem_pkg::*;
#(
  parameter int unsigned MEM_SIZE_BYTES = 65536,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned FETCH_BYTES    = 16,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDR_WIDTH-1:0]    if_addr,
  output logic [FETCH_BYTES*8-1:0] if_rdata,
  output logic                     if_ack,
  output logic                     if_err,
  input  logic                     data_req,
  input  logic                     data_we,
  input  logic [1:0]               data_size,
  input  logic [ADDR_WIDTH-1:0]    data_addr,
  input  logic [31:0]              data_wdata,
  output logic [31:0]              data_rdata,
  output logic                     data_ack,
  output logic                     data_err
);

  localparam int unsigned IDX_W = $clog2(MEM_SIZE_BYTES);
  localparam int unsigned FW    = FETCH_BYTES * 8;
  localparam logic [ADDR_WIDTH:0] MEM_END = (ADDR_WIDTH + 1)'(MEM_SIZE_BYTES);

  if (!fetch_bytes_ok(FETCH_BYTES)) begin : g_bad_fetch_bytes
    $error("banked_unified_memory: FETCH_BYTES must be 4, 8 or 16");
  end
  if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
    $error("banked_unified_memory: READ_LATENCY must be 1 or 2");
  end
  if ((MEM_SIZE_BYTES & (MEM_SIZE_BYTES - 1)) != 0 || MEM_SIZE_BYTES < FETCH_BYTES) begin : g_bad_size
    $error("banked_unified_memory: MEM_SIZE_BYTES must be a power of two >= FETCH_BYTES");
  end
  if (ADDR_WIDTH < IDX_W) begin : g_bad_addr_width
    $error("banked_unified_memory: ADDR_WIDTH too narrow for MEM_SIZE_BYTES");
  end

  logic [7:0] mem [MEM_SIZE_BYTES];

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  mem_size_e           d_size;
  logic [2:0]          d_n;
  logic [ADDR_WIDTH:0] d_end, f_end;
  logic                d_ok, f_ok, st_en;
  logic [FW-1:0]       f_data;
  logic [31:0]         l_data;

  // End addresses carry one extra bit so accesses near the top of the address space cannot wrap.
  assign d_size = mem_size_e'(data_size);
  assign d_n    = size_bytes(d_size);
  assign d_end  = {1'b0, data_addr} + (ADDR_WIDTH + 1)'(d_n);
  assign d_ok   = (d_n != 3'd0) && (d_end <= MEM_END);
  assign f_end  = {1'b0, if_addr} + (ADDR_WIDTH + 1)'(FETCH_BYTES);
  assign f_ok   = f_end <= MEM_END;
  assign st_en  = data_req && data_we && d_ok && !rst;

  always_ff @(posedge clk) begin
    if (st_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (3'(i) < d_n)
          mem[idx(data_addr + ADDR_WIDTH'(i))] <= 8'(data_wdata >> {d_n - 3'(i) - 3'd1, 3'b000});
      end
    end
  end

  // Fetch lanes overlapping this cycle's store take the store bytes instead of the array.
  always_comb begin
    logic [ADDR_WIDTH-1:0] a, off;
    logic [7:0]            b;
    a      = '0;
    off    = '0;
    b      = '0;
    f_data = '0;
    for (int unsigned i = 0; i < FETCH_BYTES; i++) begin
      a   = if_addr + ADDR_WIDTH'(i);
      off = a - data_addr;
      b   = mem[idx(a)];
      if (st_en && off < ADDR_WIDTH'(d_n))
        b = 8'(data_wdata >> {d_n - off[2:0] - 3'd1, 3'b000});
      f_data = {f_data[FW-9:0], b};
    end
    if (!f_ok)
      f_data = '0;
  end

  always_comb begin
    l_data = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (3'(i) < d_n)
        l_data = {l_data[23:0], mem[idx(data_addr + ADDR_WIDTH'(i))]};
    end
    if (data_we || !d_ok)
      l_data = '0;
  end

  mem_resp_pipe #(
    .WIDTH   (FW),
    .LATENCY (READ_LATENCY)
  ) u_if_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (if_req),
    .in_err    (!f_ok),
    .in_data   (f_data),
    .out_valid (if_ack),
    .out_err   (if_err),
    .out_data  (if_rdata)
  );

  mem_resp_pipe #(
    .WIDTH   (32),
    .LATENCY (READ_LATENCY)
  ) u_data_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (data_req),
    .in_err    (!d_ok),
    .in_data   (l_data),
    .out_valid (data_ack),
    .out_err   (data_err),
    .out_data  (data_rdata)
  );

endmodule

// File: tb/tb_banked_unified_memory.sv
// Bench for banked_unified_memory: latency-1 and latency-2 instances share stimulus and are
// checked against a byte-array reference model with per-port expected-response queues.
module tb_banked_unified_memory;

  localparam int unsigned MEM = 65536;
  localparam int unsigned FB  = 16;

  typedef struct {
    int          due;
    logic        err;
    logic [127:0] data;
  } resp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, if_req, data_req, data_we;
  logic [31:0]  if_addr, data_addr, data_wdata;
  logic [1:0]   data_size;
  logic [127:0] if_rdata1, if_rdata2;
  logic         if_ack1, if_err1, if_ack2, if_err2;
  logic [31:0]  data_rdata1, data_rdata2;
  logic         data_ack1, data_err1, data_ack2, data_err2;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int ack2_cnt = 0;

  logic [7:0] mem_m [MEM];
  resp_t q_f1[$], q_f2[$], q_d1[$], q_d2[$];

  always #5 clk = ~clk;

  banked_unified_memory #(
    .MEM_SIZE_BYTES (MEM), .ADDR_WIDTH (32), .FETCH_BYTES (FB), .READ_LATENCY (1)
  ) u_dut1 (
    .clk (clk), .rst (rst),
    .if_req (if_req), .if_addr (if_addr), .if_rdata (if_rdata1), .if_ack (if_ack1), .if_err (if_err1),
    .data_req (data_req), .data_we (data_we), .data_size (data_size), .data_addr (data_addr),
    .data_wdata (data_wdata), .data_rdata (data_rdata1), .data_ack (data_ack1), .data_err (data_err1)
  );

  banked_unified_memory #(
    .MEM_SIZE_BYTES (MEM), .ADDR_WIDTH (32), .FETCH_BYTES (FB), .READ_LATENCY (2)
  ) u_dut2 (
    .clk (clk), .rst (rst),
    .if_req (if_req), .if_addr (if_addr), .if_rdata (if_rdata2), .if_ack (if_ack2), .if_err (if_err2),
    .data_req (data_req), .data_we (data_we), .data_size (data_size), .data_addr (data_addr),
    .data_wdata (data_wdata), .data_rdata (data_rdata2), .data_ack (data_ack2), .data_err (data_err2)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [127:0] model_fetch(input logic [31:0] a);
    logic [127:0] r;
    r = '0;
    if (longint'(a) + FB > MEM) return '0;
    for (int unsigned i = 0; i < FB; i++) r = {r[119:0], mem_m[16'(a + 32'(i))]};
    return r;
  endfunction

  // Store first, then reads: this gives write-first visibility for a same-cycle fetch.
  task automatic model_accept();
    int unsigned n;
    bit          ok;
    logic [31:0] rd;
    resp_t       r;
    if (rst) begin
      q_f1.delete(); q_f2.delete(); q_d1.delete(); q_d2.delete();
      return;
    end
    if (data_req) begin
      n  = nbytes(data_size);
      ok = (n != 0) && (longint'(data_addr) + n <= MEM);
      rd = '0;
      for (int unsigned k = 0; k < n; k++) begin
        if (ok && data_we) mem_m[16'(data_addr + 32'(k))] = 8'(data_wdata >> (8 * (n - 1 - k)));
        if (ok && !data_we) rd = {rd[23:0], mem_m[16'(data_addr + 32'(k))]};
      end
      r.err  = !ok;
      r.data = 128'(rd);
      r.due  = cyc;     q_d1.push_back(r);
      r.due  = cyc + 1; q_d2.push_back(r);
    end
    if (if_req) begin
      r.err  = longint'(if_addr) + FB > MEM;
      r.data = model_fetch(if_addr);
      r.due  = cyc;     q_f1.push_back(r);
      r.due  = cyc + 1; q_f2.push_back(r);
    end
  endtask

  task automatic cmp_resp(input string nm, input bit have, input resp_t e,
                          input logic ack, input logic err, input logic [127:0] rd);
    if (have) begin
      chk({nm, " ack"}, 128'(ack), 128'd1);
      chk({nm, " err"}, 128'(err), 128'(e.err));
      chk({nm, " rdata"}, rd, e.data);
    end else begin
      chk({nm, " idle ack"}, 128'(ack), 128'd0);
      chk({nm, " idle err"}, 128'(err), 128'd0);
    end
  endtask

  task automatic check_all();
    bit    h;
    resp_t e;
    e = '{default: '0};
    h = q_f1.size() > 0 && q_f1[0].due == cyc;
    if (h) e = q_f1.pop_front();
    cmp_resp("lat1 fetch", h, e, if_ack1, if_err1, if_rdata1);
    h = q_f2.size() > 0 && q_f2[0].due == cyc;
    if (h) e = q_f2.pop_front();
    cmp_resp("lat2 fetch", h, e, if_ack2, if_err2, if_rdata2);
    h = q_d1.size() > 0 && q_d1[0].due == cyc;
    if (h) e = q_d1.pop_front();
    cmp_resp("lat1 data", h, e, data_ack1, data_err1, 128'(data_rdata1));
    h = q_d2.size() > 0 && q_d2[0].due == cyc;
    if (h) e = q_d2.pop_front();
    cmp_resp("lat2 data", h, e, data_ack2, data_err2, 128'(data_rdata2));
    if (data_ack2) ack2_cnt++;
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_accept();
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic ir, input logic [31:0] ia, input logic dr,
                       input logic we, input logic [1:0] sz, input logic [31:0] da, input logic [31:0] wd);
    rst = r; if_req = ir; if_addr = ia;
    data_req = dr; data_we = we; data_size = sz; data_addr = da; data_wdata = wd;
    cycle();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, " if_ack1"}, 128'(if_ack1), 128'd0);
    chk({nm, " if_err1"}, 128'(if_err1), 128'd0);
    chk({nm, " if_rdata1"}, if_rdata1, 128'd0);
    chk({nm, " data_ack1"}, 128'(data_ack1), 128'd0);
    chk({nm, " data_err1"}, 128'(data_err1), 128'd0);
    chk({nm, " data_rdata1"}, 128'(data_rdata1), 128'd0);
    chk({nm, " if_ack2"}, 128'(if_ack2), 128'd0);
    chk({nm, " if_rdata2"}, if_rdata2, 128'd0);
    chk({nm, " data_ack2"}, 128'(data_ack2), 128'd0);
    chk({nm, " data_rdata2"}, 128'(data_rdata2), 128'd0);
  endtask

  function automatic logic [31:0] pick_addr(input int unsigned span);
    case ($urandom_range(0, 9))
      0:          return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      1:          return 32'h0001_0000 - span + $urandom_range(0, span + 3);
      2, 3, 4, 5: return 32'($urandom_range(0, 32'h400 - span));
      default:    return 32'hFC00 + $urandom_range(0, 32'h400 - span);
    endcase
  endfunction

  initial begin
    vec_t         tbl[14];
    logic [127:0] exp_f;
    logic [7:0]   saved[3];
    logic [31:0]  w300;

    tbl[0]  = '{1'b1, 2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 2'b10, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b0, 2'b00, 32'h0000_0101, 32'h0000_0000, 1'b0, 32'h0000_00AD};
    tbl[3]  = '{1'b0, 2'b01, 32'h0000_0102, 32'h0000_0000, 1'b0, 32'h0000_BEEF};
    tbl[4]  = '{1'b1, 2'b10, 32'h0000_0104, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
    tbl[5]  = '{1'b1, 2'b11, 32'h0000_0104, 32'h1122_3344, 1'b1, 32'h0000_0000};
    tbl[6]  = '{1'b0, 2'b10, 32'h0000_0104, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
    tbl[7]  = '{1'b1, 2'b01, 32'h0000_010A, 32'hFFFF_ABCD, 1'b0, 32'h0000_0000};
    tbl[8]  = '{1'b0, 2'b00, 32'h0000_010B, 32'h0000_0000, 1'b0, 32'h0000_00CD};
    tbl[9]  = '{1'b0, 2'b01, 32'h0000_010A, 32'h0000_0000, 1'b0, 32'h0000_ABCD};
    tbl[10] = '{1'b0, 2'b10, 32'h0000_FFFD, 32'h0000_0000, 1'b1, 32'h0000_0000};
    tbl[11] = '{1'b0, 2'b01, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000};
    tbl[12] = '{1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000};
    tbl[13] = '{1'b0, 2'b11, 32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_0000};

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

    // Give both known regions defined contents so every later read has a model value.
    for (int unsigned a = 0; a < 32'h400; a += 4)
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2'b10, a, $urandom);
    for (int unsigned a = 32'hFC00; a < 32'h10000; a += 4)
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2'b10, a, $urandom);

    // Requests held high through a 2-cycle reset are dropped.
    w300 = {mem_m[16'h300], mem_m[16'h301], mem_m[16'h302], mem_m[16'h303]};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 2'b10, 32'h300, 32'h1234_5678);
      chk_quiet($sformatf("reset_hold%0d", i));
    end
    idle();
    chk_quiet("reset_after");
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h300, 32'h0);
    chk("reset_no_write", 128'(data_rdata1), 128'(w300));

    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("tbl%0d ack", i), 128'(data_ack1), 128'd1);
      chk($sformatf("tbl%0d err", i), 128'(data_err1), 128'(tbl[i].e_err));
      chk($sformatf("tbl%0d rdata", i), 128'(data_rdata1), 128'(tbl[i].e_rdata));
    end

    exp_f = model_fetch(32'hFFF0);
    drive(1'b0, 1'b1, 32'hFFF0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("fetch_fff0 ack", 128'(if_ack1), 128'd1);
    chk("fetch_fff0 err", 128'(if_err1), 128'd0);
    chk("fetch_fff0 rdata", if_rdata1, exp_f);
    drive(1'b0, 1'b1, 32'hFFF1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("fetch_fff1 ack", 128'(if_ack1), 128'd1);
    chk("fetch_fff1 err", 128'(if_err1), 128'd1);
    chk("fetch_fff1 rdata", if_rdata1, 128'd0);

    saved[0] = mem_m[16'hFFFD]; saved[1] = mem_m[16'hFFFE]; saved[2] = mem_m[16'hFFFF];
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'hFFFD, 32'h0102_0304);
    chk("store_fffd err", 128'(data_err1), 128'd1);
    for (int unsigned k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 32'hFFFD + k, 32'h0);
      chk($sformatf("no_partial_write %0d", k), 128'(data_rdata1), 128'(saved[k]));
    end

    exp_f = model_fetch(32'h200);
    exp_f[87:80] = 8'h55;
    drive(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 2'b00, 32'h205, 32'hAAAA_AA55);
    chk("fwd_fetch lanes", if_rdata1, exp_f);

    idle(); idle();
    ack2_cnt = 0;
    for (int unsigned i = 0; i < 8; i++)
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'b10, 32'h100 + 4 * i, 32'h0);
    idle(); idle();
    chk("lat2_burst ack count", 128'(ack2_cnt), 128'd8);

    drive(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("rst_drop if_ack2 0", 128'(if_ack2), 128'd0);
    for (int i = 1; i < 3; i++) begin
      idle();
      chk($sformatf("rst_drop if_ack2 %0d", i), 128'(if_ack2), 128'd0);
    end

    for (int n = 0; n < 800; n++) begin
      logic       r, ir, dr, we;
      logic [1:0] sz;
      r  = ($urandom_range(0, 99) == 0);
      ir = 1'($urandom_range(0, 1));
      dr = ($urandom_range(0, 9) < 7);
      we = ($urandom_range(0, 2) == 0);
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      drive(r, ir, pick_addr(FB), dr, we, sz, pick_addr(4), $urandom);
    end

    idle(); idle(); idle();
    chk("queues_drained", 128'(q_f1.size() + q_f2.size() + q_d1.size() + q_d2.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
